// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction from ID, forwarding sources from EX/MEM and MEM/WB,
// and the operand/control bundle presented to the ALU and carried toward MEM.
interface id_ex_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CTL_W   = 4
);
  logic               IdValid_i;
  logic [CTL_W-1:0]   IdALUCtl_i;
  logic [RADDR_W-1:0] IdRs1Addr_i;
  logic [RADDR_W-1:0] IdRs2Addr_i;
  logic [XLEN-1:0]    IdRs1Data_i;
  logic [XLEN-1:0]    IdRs2Data_i;
  logic [XLEN-1:0]    IdImm_i;
  logic               IdUseImm_i;
  logic [RADDR_W-1:0] IdRdAddr_i;
  logic               IdRegWrite_i;

  logic [RADDR_W-1:0] MemRdAddr_i;
  logic               MemRegWrite_i;
  logic [XLEN-1:0]    MemRes_i;
  logic [RADDR_W-1:0] WbRdAddr_i;
  logic               WbRegWrite_i;
  logic [XLEN-1:0]    WbData_i;

  logic               Valid_o;
  logic [CTL_W-1:0]   ALUCtl_o;
  logic [XLEN-1:0]    Op1_o;
  logic [XLEN-1:0]    Op2_o;
  logic [XLEN-1:0]    StoreData_o;
  logic [RADDR_W-1:0] RdAddr_o;
  logic               RegWrite_o;

  modport master (
    output IdValid_i, IdALUCtl_i, IdRs1Addr_i, IdRs2Addr_i, IdRs1Data_i, IdRs2Data_i,
           IdImm_i, IdUseImm_i, IdRdAddr_i, IdRegWrite_i,
           MemRdAddr_i, MemRegWrite_i, MemRes_i, WbRdAddr_i, WbRegWrite_i, WbData_i,
    input  Valid_o, ALUCtl_o, Op1_o, Op2_o, StoreData_o, RdAddr_o, RegWrite_o
  );

  modport slave (
    input  IdValid_i, IdALUCtl_i, IdRs1Addr_i, IdRs2Addr_i, IdRs1Data_i, IdRs2Data_i,
           IdImm_i, IdUseImm_i, IdRdAddr_i, IdRegWrite_i,
           MemRdAddr_i, MemRegWrite_i, MemRes_i, WbRdAddr_i, WbRegWrite_i, WbData_i,
    output Valid_o, ALUCtl_o, Op1_o, Op2_o, StoreData_o, RdAddr_o, RegWrite_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW forwarding into the ALU operand muxes.
// Define ID_EX_FWD_EN to enable forwarding; otherwise operands come straight from the stage registers.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CTL_W   = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          stall_i,
  input logic          flush_i,
  id_ex_stage_if.slave bus
);

  logic               valid_q,     valid_d;
  logic [CTL_W-1:0]   alu_ctl_q,   alu_ctl_d;
  logic [RADDR_W-1:0] rs1_addr_q,  rs1_addr_d;
  logic [RADDR_W-1:0] rs2_addr_q,  rs2_addr_d;
  logic [XLEN-1:0]    rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]    rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]    imm_q,       imm_d;
  logic               use_imm_q,   use_imm_d;
  logic [RADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic               reg_write_q, reg_write_d;

  logic [XLEN-1:0]    rs1_fwd;
  logic [XLEN-1:0]    rs2_fwd;

  // Reset lives in the flop process; flush beats stall beats load here.
  always_comb begin
    valid_d     = valid_q;
    alu_ctl_d   = alu_ctl_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    rd_addr_d   = rd_addr_q;
    reg_write_d = reg_write_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      alu_ctl_d   = '0;
      rs1_addr_d  = '0;
      rs2_addr_d  = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      use_imm_d   = 1'b0;
      rd_addr_d   = '0;
      reg_write_d = 1'b0;
    end else if (!stall_i) begin
      valid_d     = bus.IdValid_i;
      alu_ctl_d   = bus.IdALUCtl_i;
      rs1_addr_d  = bus.IdRs1Addr_i;
      rs2_addr_d  = bus.IdRs2Addr_i;
      rs1_data_d  = bus.IdRs1Data_i;
      rs2_data_d  = bus.IdRs2Data_i;
      imm_d       = bus.IdImm_i;
      use_imm_d   = bus.IdUseImm_i;
      rd_addr_d   = bus.IdRdAddr_i;
      reg_write_d = bus.IdRegWrite_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      alu_ctl_q   <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_ctl_q   <= alu_ctl_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
    end
  end

`ifdef ID_EX_FWD_EN
  // EX/MEM is the younger producer, so it is checked first; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [RADDR_W-1:0] src_addr,
                                              input logic [XLEN-1:0]    reg_data);
    logic [XLEN-1:0] sel;
    sel = reg_data;
    if (src_addr != '0) begin
      if (bus.MemRegWrite_i && (bus.MemRdAddr_i == src_addr)) begin
        sel = bus.MemRes_i;
      end else if (bus.WbRegWrite_i && (bus.WbRdAddr_i == src_addr)) begin
        sel = bus.WbData_i;
      end
    end
    return sel;
  endfunction

  always_comb begin
    rs1_fwd = fwd_sel(rs1_addr_q, rs1_data_q);
    rs2_fwd = fwd_sel(rs2_addr_q, rs2_data_q);
  end
`else
  // Without forwarding the hazard unit stalls instead; producer ports stay but are ignored.
  logic unused_fwd;
  assign unused_fwd = ^{bus.MemRdAddr_i, bus.MemRegWrite_i, bus.MemRes_i,
                        bus.WbRdAddr_i, bus.WbRegWrite_i, bus.WbData_i,
                        rs1_addr_q, rs2_addr_q};

  assign rs1_fwd = rs1_data_q;
  assign rs2_fwd = rs2_data_q;
`endif

  assign bus.Valid_o     = valid_q;
  assign bus.ALUCtl_o    = alu_ctl_q;
  assign bus.Op1_o       = rs1_fwd;
  assign bus.Op2_o       = use_imm_q ? imm_q : rs2_fwd;
  assign bus.StoreData_o = rs2_fwd;
  assign bus.RdAddr_o    = rd_addr_q;
  assign bus.RegWrite_o  = reg_write_q & valid_q;

endmodule
